dmem_mmio: RTL and testbench
============================

# dmem_mmio

Data-side memory responder for the single-cycle MIPS core. It answers the core's data-port accesses: `memwrite` with the ALU result as address, `writedata`, and `readdata`. Word RAM occupies the low address region. A small memory-mapped I/O window provides a byte-wide transmit FIFO, with a valid/ready stream toward a downstream sink, and a free-running cycle counter. It sits in the top level beside instruction memory.

## Interface
Parameters:
- `RAM_WORDS`, default 64: data RAM depth in 32-bit words; must be a power of two.
- `FIFO_DEPTH`, default 8: transmit FIFO depth in bytes; must be a power of two, at least 2.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `memwrite`, input, 1: write strobe from the core.
- `addr`, input, 32: byte address (the core's `aluout`); `addr[1:0]` is ignored.
- `writedata`, input, 32: store data.
- `readdata`, output, 32: load data, combinational from `addr`.
- `tx_data`, output, 8: FIFO head byte.
- `tx_valid`, output, 1: FIFO non-empty.
- `tx_ready`, input, 1: sink accepts `tx_data` this cycle.

## Operation
Address decode, by word address:
- RAM: `addr < RAM_WORDS*4`, indexed by `addr[log2(RAM_WORDS)+1:2]`.
- TXDATA at `0xFFFF_0000`:
  - Write pushes `writedata[7:0]` into the FIFO.
  - Read returns 0.
- STATUS at `0xFFFF_0004`, read fields:
  - bit0: empty.
  - bit1: full.
  - bit2: overflow (sticky).
  - bits[15:8]: occupancy count.
  - all other bits: 0.
- STATUS write: a 1 in bit2 clears overflow; all other write bits are ignored.
- CYCLE at `0xFFFF_0008`:
  - Read returns the 32-bit counter.
  - Write loads `writedata` into the counter.
- Any other address: reads return 0; writes are dropped.

Read and write rules:
- Reads have no side effects.
- `readdata` is purely combinational, so the single-cycle core sees load data in the same cycle.

FIFO behaviour:
- A push when full and with no pop in the same cycle is dropped and sets overflow.
- A pop occurs when `tx_valid && tx_ready`.
- Push and pop in the same cycle:
  - Full: both are accepted; the count stays at DEPTH; no overflow.
  - Empty: there is no pop (`tx_valid`=0); the push is accepted.
- Read and write pointers wrap modulo FIFO_DEPTH. The count is held separately, width log2(FIFO_DEPTH)+1.

CYCLE counter:
- Increments by 1 every cycle and wraps from `0xFFFF_FFFF` to 0.
- A CPU write takes precedence over the increment in that cycle.

Overflow flag:
- If a set event and a STATUS clear write occur in the same cycle, set wins.

## Timing
Reset values (`reset` low, asynchronous):
- FIFO pointers and count = 0.
- overflow = 0.
- CYCLE = 0.
- `tx_valid` = 0.
- `tx_data` = 0.

Reset does not initialise RAM contents; they are undefined until written.

Write and read latency:
- Writes commit on the rising edge where `memwrite`=1.
- A `readdata` read in that same cycle returns the pre-edge value (no write-through).

FIFO latency:
- A pushed byte appears on `tx_valid`/`tx_data` one cycle after the push edge.
- After a pop, `tx_data` shows the next entry on the following cycle.

Stream rules:
- `tx_data` is stable while `tx_valid`=1 and `tx_ready`=0.
- `tx_valid` never drops without a pop.

Reset asserted mid-transfer empties the FIFO immediately; the sink sees `tx_valid` fall asynchronously.

## Structure
- Package `mips_mmio_pkg`:
  - address constants `MMIO_TXDATA`, `MMIO_STATUS`, `MMIO_CYCLE`.
  - STATUS bit-position constants.
  - a decoded-region enum (RAM, TXDATA, STATUS, CYCLE, NONE).
- Sub-module `sync_fifo`:
  - parameterised width and depth.
  - ports: push, pop, din, dout, empty, full, count.
  - same-cycle push and pop when full, as specified above.
- The top level holds the RAM array, address decode, counter, overflow flag and read mux.

## Test plan
- RAM: write `0xDEADBEEF` to address 0x3C, then read 0x3C → `0xDEADBEEF`. Read 0x3E → same word. Read 0x100 (out of range for RAM_WORDS=64) → 0.
- FIFO: hold `tx_ready`=0 and push 0x41, 0x42, 0x43 → STATUS = `0x0000_0300`, `tx_data`=0x41. Raise `tx_ready` → 0x41, 0x42, 0x43 delivered on consecutive cycles, then `tx_valid`=0 and STATUS = `0x0000_0001`.
- Full and overflow: push 9 bytes with `tx_ready`=0 → the 9th is dropped and STATUS = `0x0000_0806`. A STATUS write of 0x4 clears bit2. A push while full with `tx_ready`=1 in the same cycle → accepted, count stays 8, no overflow.
- CYCLE: write `0xFFFF_FFFE`, read on the next cycle → `0xFFFF_FFFE`. Two cycles later → 0 (wrap).
- Reset: with 3 bytes queued, pull `reset` low mid-cycle → `tx_valid`=0 immediately. After release, STATUS = `0x0000_0001`.

Source files
------------

// File: rtl/mips_mmio_pkg.sv
// mips_mmio_pkg: shared address map, STATUS bit positions and region decode for the data-side responder.
package mips_mmio_pkg;
   localparam logic [31:0] MMIO_TXDATA = 32'hFFFF_0000;
   localparam logic [31:0] MMIO_STATUS = 32'hFFFF_0004;
   localparam logic [31:0] MMIO_CYCLE  = 32'hFFFF_0008;
   localparam int ST_EMPTY = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_OVF   = 2;
   localparam int ST_COUNT = 8;
   typedef enum logic [2:0] {REG_RAM, REG_TXDATA, REG_STATUS, REG_CYCLE, REG_NONE} region_e;
   // Word-granular match: addr[1:0] never takes part in the decode.
   function automatic region_e decode(input logic [31:0] addr, input logic [31:0] ram_bytes);
      return (addr < ram_bytes)                ? REG_RAM    :
             (addr[31:2] == MMIO_TXDATA[31:2]) ? REG_TXDATA :
             (addr[31:2] == MMIO_STATUS[31:2]) ? REG_STATUS :
             (addr[31:2] == MMIO_CYCLE[31:2])  ? REG_CYCLE  : REG_NONE;
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a separate occupancy count; a full FIFO accepts push and pop together.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;
   always_comb begin
      empty   = cnt_q == '0;
      full    = cnt_q == CW'(DEPTH);
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      wr_d    = do_push ? wr_q + PW'(1) : wr_q;
      rd_d    = do_pop ? rd_q + PW'(1) : rd_q;
      cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
      count   = cnt_q;
      dout    = empty ? '0 : mem_q[rd_q];
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din;
   end
endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: data RAM plus MMIO window (transmit FIFO, STATUS, free-running CYCLE counter) for the single-cycle core.
module dmem_mmio
   import mips_mmio_pkg::*;
#(
   parameter int RAM_WORDS  = 64,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] addr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);
   localparam int AW = $clog2(RAM_WORDS);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   region_e     region;
   logic [31:0] ram_q [RAM_WORDS];
   logic [31:0] cyc_q, cyc_d, status;
   logic        ovf_q, ovf_d;
   logic        push, pop, empty, full;
   logic [CW-1:0] count;
   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .din(writedata[7:0]),
      .dout(tx_data), .empty(empty), .full(full), .count(count)
   );
   always_comb begin
      region   = decode(addr, 32'(RAM_WORDS * 4));
      push     = memwrite && region == REG_TXDATA;
      tx_valid = !empty;
      pop      = tx_valid && tx_ready;
      // A dropped push beats a same-cycle clear so no overflow event is lost.
      ovf_d    = (push && full && !pop) ? 1'b1 :
                 (memwrite && region == REG_STATUS && writedata[ST_OVF]) ? 1'b0 : ovf_q;
      cyc_d    = (memwrite && region == REG_CYCLE) ? writedata : cyc_q + 32'd1;
      status   = '0;
      status[ST_EMPTY] = empty;
      status[ST_FULL]  = full;
      status[ST_OVF]   = ovf_q;
      status[ST_COUNT +: 8] = 8'(count);
      readdata = (region == REG_RAM)    ? ram_q[addr[AW+1:2]] :
                 (region == REG_STATUS) ? status :
                 (region == REG_CYCLE)  ? cyc_q : '0;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_q <= 1'b0;
         cyc_q <= '0;
      end else begin
         ovf_q <= ovf_d;
         cyc_q <= cyc_d;
      end
   end
   always_ff @(posedge clk) begin
      if (memwrite && region == REG_RAM) ram_q[addr[AW+1:2]] <= writedata;
   end
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed checks of RAM, FIFO stream, STATUS, CYCLE and reset; transmitted bytes tracked by a scoreboard queue.
module tb_dmem_mmio;
   import mips_mmio_pkg::*;
   logic        clk = 0, reset = 0, memwrite = 0, tx_ready = 0;
   logic [31:0] addr = 0, writedata = 0;
   logic [31:0] readdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   int          checks = 0, errors = 0;
   logic [7:0]  sbq [$];
   dmem_mmio dut (
      .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr), .writedata(writedata),
      .readdata(readdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a;
      writedata = d;
      memwrite = 1;
      @(posedge clk);
      #1 memwrite = 0;
   endtask
   task automatic push(input logic [7:0] b);
      sbq.push_back(b);
      wr(MMIO_TXDATA, {24'b0, b});
   endtask
   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
      addr = a;
      #1 chk(tag, readdata, exp);
   endtask
   task automatic drain_one(input string tag);
      logic [7:0] e;
      e = (sbq.size() != 0) ? sbq.pop_front() : 8'hxx;
      chk({tag, "_valid"}, {31'b0, tx_valid}, 32'd1);
      chk(tag, {24'b0, tx_data}, {24'b0, e});
      @(posedge clk);
      #1;
   endtask
   initial begin
      #2;
      chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
      chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
      rd(MMIO_STATUS, 32'h1, "rst_status");
      rd(MMIO_CYCLE, 32'h0, "rst_cycle");
      @(negedge clk) reset = 1;
      @(posedge clk);
      #1;
      wr(32'h3C, 32'hDEADBEEF);
      rd(32'h3C, 32'hDEADBEEF, "ram_rd");
      rd(32'h3E, 32'hDEADBEEF, "ram_rd_unaligned");
      rd(32'h100, 32'h0, "ram_out_of_range");
      addr = 32'h3C;
      writedata = 32'h1234_5678;
      memwrite = 1;
      #1 chk("ram_no_writethrough", readdata, 32'hDEADBEEF);
      @(posedge clk);
      #1 memwrite = 0;
      rd(32'h3C, 32'h1234_5678, "ram_rewrite");
      wr(32'hFFFF_000C, 32'h5);
      rd(32'hFFFF_000C, 32'h0, "unmapped_rd");
      rd(MMIO_TXDATA, 32'h0, "txdata_rd");
      rd(MMIO_STATUS, 32'h1, "unmapped_no_push");
      push(8'h41);
      push(8'h42);
      push(8'h43);
      rd(MMIO_STATUS, 32'h0000_0300, "status_three");
      chk("head_held", {24'b0, tx_data}, 32'h41);
      tx_ready = 1;
      drain_one("drain_a");
      drain_one("drain_b");
      drain_one("drain_c");
      tx_ready = 0;
      chk("drained_valid", {31'b0, tx_valid}, 32'd0);
      rd(MMIO_STATUS, 32'h1, "status_empty");
      for (int i = 0; i < 8; i++) push(8'(8'h50 + i));
      wr(MMIO_TXDATA, 32'h99);
      rd(MMIO_STATUS, 32'h0000_0806, "status_overflow");
      chk("full_head", {24'b0, tx_data}, 32'h50);
      wr(MMIO_STATUS, 32'h4);
      rd(MMIO_STATUS, 32'h0000_0802, "ovf_cleared");
      tx_ready = 1;
      chk("full_pushpop_head", {24'b0, tx_data}, {24'b0, sbq[0]});
      void'(sbq.pop_front());
      push(8'h77);
      tx_ready = 0;
      rd(MMIO_STATUS, 32'h0000_0802, "full_pushpop_status");
      tx_ready = 1;
      for (int i = 0; i < 8; i++) drain_one($sformatf("drain_full_%0d", i));
      tx_ready = 0;
      chk("full_drained_valid", {31'b0, tx_valid}, 32'd0);
      rd(MMIO_STATUS, 32'h1, "status_empty2");
      wr(MMIO_CYCLE, 32'hFFFF_FFFE);
      rd(MMIO_CYCLE, 32'hFFFF_FFFE, "cycle_load");
      @(posedge clk);
      #1 rd(MMIO_CYCLE, 32'hFFFF_FFFF, "cycle_inc");
      @(posedge clk);
      #1 rd(MMIO_CYCLE, 32'h0, "cycle_wrap");
      push(8'hA1);
      push(8'hA2);
      push(8'hA3);
      #1 chk("pre_reset_valid", {31'b0, tx_valid}, 32'd1);
      #2 reset = 0;
      #1 chk("async_reset_valid", {31'b0, tx_valid}, 32'd0);
      chk("async_reset_data", {24'b0, tx_data}, 32'd0);
      sbq.delete();
      #2 reset = 1;
      rd(MMIO_STATUS, 32'h1, "post_reset_status");
      rd(MMIO_CYCLE, 32'h0, "post_reset_cycle");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
